seven_seg_capture: RTL and testbench

//  Receive end of the stopwatch multiplexed 7-segment bus: samples the 8-bit segment/select

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/seven_seg_decode.sv | 23 ++
 rtl/seven_seg_capture.sv | 156 +++++++++++++++
 tb/tb_seven_seg_capture.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared 7-segment definitions for the stopwatch display encoder and the capture block.
// Patterns are "lit" (active-high) with bit0 = segment a .. bit6 = segment g.
package stopwatch_pkg;

  localparam logic [6:0] SEG_HEX_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic       SEL_LSB   = 1'b1;

  typedef enum logic {
    PAIR_IDLE = 1'b0,
    PAIR_HALF = 1'b1
  } pair_state_e;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational 7-segment decoder: lit pattern -> hex nibble, with hex/blank classification.
module seven_seg_decode (
  input  logic [6:0] i_lit,
  output logic [3:0] o_nibble,
  output logic       o_is_hex,
  output logic       o_is_blank
);
  import stopwatch_pkg::*;

  always_comb begin
    o_nibble = '0;
    o_is_hex = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i_lit == SEG_HEX_LUT[i]) begin
        o_nibble = 4'(i);
        o_is_hex = 1'b1;
      end
    end
  end

  assign o_is_blank = (i_lit == SEG_BLANK);

endmodule

// File: rtl/seven_seg_capture.sv
// Receive side of the multiplexed 7-segment bus: sync, glitch filter, digit pairing, link timeout.
//
//   state     | meaning
//   PAIR_IDLE | no digit pending; next accepted digit starts a pair
//   PAIR_HALF | one half captured (see msb/lsb fresh flags); waiting for the other half
module seven_seg_capture #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       value_update,
  output logic       digit_err,
  output logic [7:0] err_count
);
  import stopwatch_pkg::*;

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_PRE = SW'(STABLE_CYCLES - 2);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_PRE   = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0][7:0] r_sync;
  logic [7:0]    r_last;
  logic [SW-1:0] r_stab_cnt;
  logic          r_accept;
  logic [TW-1:0] r_to_cnt;

  pair_state_e   r_state;
  logic          r_msb_fresh;
  logic          r_lsb_fresh;
  logic [3:0]    r_msb_nib;
  logic [3:0]    r_lsb_nib;
  logic [7:0]    r_value;
  logic          r_value_valid;
  logic          r_value_update;
  logic          r_digit_err;
  logic [7:0]    r_err_count;

  logic [7:0] w_synced;
  logic [6:0] w_lit;
  logic [3:0] w_nibble;
  logic       w_is_hex;
  logic       w_is_blank;
  logic       w_sel_lsb;
  logic       w_same_half;

  // Reset to blank with MSB select so no digit is seen coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{8'h7F}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], seg_in};
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Accept is registered, so it lines up with the cycle the count reaches its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= 8'h7F;
      r_stab_cnt <= '0;
      r_accept   <= 1'b0;
    end else if (w_synced != r_last) begin
      r_last     <= w_synced;
      r_stab_cnt <= '0;
      r_accept   <= 1'b0;
    end else if (r_stab_cnt != STAB_MAX) begin
      r_stab_cnt <= r_stab_cnt + 1'b1;
      r_accept   <= (r_stab_cnt == STAB_PRE);
    end else begin
      r_accept   <= 1'b0;
    end
  end

  assign w_lit       = ~r_last[6:0];
  assign w_sel_lsb   = (r_last[7] == SEL_LSB);
  assign w_same_half = w_sel_lsb ? r_lsb_fresh : r_msb_fresh;

  seven_seg_decode u_decode (
    .i_lit      (w_lit),
    .o_nibble   (w_nibble),
    .o_is_hex   (w_is_hex),
    .o_is_blank (w_is_blank)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= PAIR_IDLE;
      r_msb_fresh    <= 1'b0;
      r_lsb_fresh    <= 1'b0;
      r_msb_nib      <= '0;
      r_lsb_nib      <= '0;
      r_value        <= 8'h00;
      r_value_valid  <= 1'b0;
      r_value_update <= 1'b0;
      r_digit_err    <= 1'b0;
      r_err_count    <= 8'h00;
      r_to_cnt       <= '0;
    end else begin
      r_value_update <= 1'b0;
      r_digit_err    <= 1'b0;
      // An accept in the same cycle as the timeout wins.
      if (r_accept) begin
        r_to_cnt <= '0;
        if (w_is_hex) begin
          if (r_state == PAIR_IDLE || w_same_half) begin
            if (w_sel_lsb) begin
              r_lsb_nib   <= w_nibble;
              r_lsb_fresh <= 1'b1;
            end else begin
              r_msb_nib   <= w_nibble;
              r_msb_fresh <= 1'b1;
            end
            r_state <= PAIR_HALF;
          end else begin
            r_value        <= w_sel_lsb ? {r_msb_nib, w_nibble} : {w_nibble, r_lsb_nib};
            r_value_valid  <= 1'b1;
            r_value_update <= 1'b1;
            r_msb_fresh    <= 1'b0;
            r_lsb_fresh    <= 1'b0;
            r_state        <= PAIR_IDLE;
          end
        end else if (!w_is_blank) begin
          r_digit_err <= 1'b1;
          if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
          r_msb_fresh <= 1'b0;
          r_lsb_fresh <= 1'b0;
          r_state     <= PAIR_IDLE;
        end
      end else if (r_to_cnt != TO_MAX) begin
        r_to_cnt <= r_to_cnt + 1'b1;
        if (r_to_cnt == TO_PRE) begin
          r_value_valid <= 1'b0;
          r_msb_fresh   <= 1'b0;
          r_lsb_fresh   <= 1'b0;
          r_state       <= PAIR_IDLE;
        end
      end
    end
  end

  assign value        = r_value;
  assign value_valid  = r_value_valid;
  assign value_update = r_value_update;
  assign digit_err    = r_digit_err;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: vector table for digit pairing plus latency,
// timeout, reset and error-saturation sequences.
module tb_seven_seg_capture;

  localparam int SYNC_STAGES    = 2;
  localparam int STABLE_CYCLES  = 16;
  localparam int TIMEOUT_CYCLES = 4096;
  localparam int LATENCY        = SYNC_STAGES + STABLE_CYCLES + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg_in = 8'h7F;
  logic [7:0] value;
  logic       value_valid;
  logic       value_update;
  logic       digit_err;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int n_upd = 0;
  int n_err = 0;

  seven_seg_capture #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .value       (value),
    .value_valid (value_valid),
    .value_update(value_update),
    .digit_err   (digit_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, including while reset is asserted.
  always @(negedge clk) begin
    if (value_update) n_upd <= n_upd + 1;
    if (digit_err)    n_err <= n_err + 1;
  end

  typedef struct {
    logic [7:0] seg;
    int         hold;
    logic [7:0] exp_value;
    logic       exp_valid;
    int         exp_upd;
    int         exp_err;
    logic [7:0] exp_errc;
  } vec_t;

  vec_t vecs [15];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int u0, e0, k;
    bit seen;

    // Digit patterns (active-low, bit7 select): '4'M=19 '2'L=A4 '9'M=10 '3'L=B0
    // 'F'M=0E '0'L=C0 'A'M=08 '8'M=00 'b'L=83, blank 7F/FF, invalid 7E/7D/A6.
    vecs[0]  = '{8'h19, 40, 8'h42, 1'b1, 0, 0, 8'h00};
    vecs[1]  = '{8'hA6,  5, 8'h42, 1'b1, 0, 0, 8'h00};
    vecs[2]  = '{8'h19, 40, 8'h42, 1'b1, 0, 0, 8'h00};
    vecs[3]  = '{8'hA4, 40, 8'h42, 1'b1, 1, 0, 8'h00};
    vecs[4]  = '{8'h19, 40, 8'h42, 1'b1, 0, 0, 8'h00};
    vecs[5]  = '{8'h7E, 64, 8'h42, 1'b1, 0, 1, 8'h01};
    vecs[6]  = '{8'hA4, 40, 8'h42, 1'b1, 0, 0, 8'h01};
    vecs[7]  = '{8'h10, 40, 8'h92, 1'b1, 1, 0, 8'h01};
    vecs[8]  = '{8'hB0, 40, 8'h92, 1'b1, 0, 0, 8'h01};
    vecs[9]  = '{8'h0E, 40, 8'hF3, 1'b1, 1, 0, 8'h01};
    vecs[10] = '{8'hFF, 40, 8'hF3, 1'b1, 0, 0, 8'h01};
    vecs[11] = '{8'hC0, 40, 8'hF3, 1'b1, 0, 0, 8'h01};
    vecs[12] = '{8'h08, 40, 8'hA0, 1'b1, 1, 0, 8'h01};
    vecs[13] = '{8'h00, 40, 8'hA0, 1'b1, 0, 0, 8'h01};
    vecs[14] = '{8'h83, 40, 8'h8B, 1'b1, 1, 0, 8'h01};

    // Reset values
    tick(3);
    check("rst_value", value, 8'h00);
    check("rst_valid", value_valid, 1'b0);
    check("rst_update", value_update, 1'b0);
    check("rst_err", digit_err, 1'b0);
    check("rst_errcount", err_count, 8'h00);
    rst_n = 1'b1;
    tick(40);
    check("post_rst_no_pulses", n_upd + n_err, 0);

    // First pair with exact latency
    seg_in = 8'h19;
    tick(1024);
    check("msb_only_valid", value_valid, 1'b0);
    u0 = n_upd;
    seg_in = 8'hA4;
    k = 0;
    seen = 0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      tick(1);
      if (value_update) begin
        seen = 1;
        k = i;
      end
    end
    check("first_update_latency", k, LATENCY);
    tick(1024);
    check("first_value", value, 8'h42);
    check("first_valid", value_valid, 1'b1);
    check("first_single_update", n_upd - u0, 1);

    // Table: glitch, overwrite, republish, error discarding a half, assorted digits
    for (int v = 0; v < 15; v++) begin
      u0 = n_upd;
      e0 = n_err;
      seg_in = vecs[v].seg;
      tick(vecs[v].hold);
      check($sformatf("vec%0d_value", v), value, vecs[v].exp_value);
      check($sformatf("vec%0d_valid", v), value_valid, vecs[v].exp_valid);
      check($sformatf("vec%0d_updates", v), n_upd - u0, vecs[v].exp_upd);
      check($sformatf("vec%0d_errs", v), n_err - e0, vecs[v].exp_err);
      check($sformatf("vec%0d_errcount", v), err_count, vecs[v].exp_errc);
    end

    // Alternating blanks keep the link alive well past the timeout
    u0 = n_upd;
    e0 = n_err;
    for (int i = 0; i < 313; i++) begin
      seg_in = i[0] ? 8'hFF : 8'h7F;
      tick(32);
    end
    check("blank_valid", value_valid, 1'b1);
    check("blank_value", value, 8'h8B);
    check("blank_updates", n_upd - u0, 0);
    check("blank_errs", n_err - e0, 0);

    // Timeout after a frozen bus
    seg_in = 8'h19;
    tick(40);
    seg_in = 8'hA4;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick(1);
      if (value_update) seen = 1;
    end
    check("timeout_setup_update_seen", seen, 1'b1);
    tick(TIMEOUT_CYCLES - 1);
    check("timeout_valid_before", value_valid, 1'b1);
    tick(1);
    check("timeout_valid_after", value_valid, 1'b0);
    check("timeout_value_kept", value, 8'h42);
    seg_in = 8'h19;
    tick(40);
    seg_in = 8'hA4;
    tick(40);
    check("relock_valid", value_valid, 1'b1);
    check("relock_value", value, 8'h42);

    // Reset while a MSB half is pending
    seg_in = 8'h10;
    tick(40);
    check("pre_reset_errcount", err_count, 8'h01);
    u0 = n_upd;
    e0 = n_err;
    seg_in = 8'h7F;
    rst_n = 1'b0;
    #1;
    check("mid_rst_value", value, 8'h00);
    check("mid_rst_valid", value_valid, 1'b0);
    check("mid_rst_errcount", err_count, 8'h00);
    tick(3);
    rst_n = 1'b1;
    tick(40);
    check("reset_exit_pulses", (n_upd - u0) + (n_err - e0), 0);
    seg_in = 8'hB0;
    tick(40);
    check("lsb_alone_updates", n_upd - u0, 0);
    check("lsb_alone_valid", value_valid, 1'b0);
    seg_in = 8'h10;
    tick(40);
    check("pair93_value", value, 8'h93);
    check("pair93_valid", value_valid, 1'b1);
    check("pair93_updates", n_upd - u0, 1);

    // Error counter saturation
    e0 = n_err;
    for (int i = 0; i < 300; i++) begin
      seg_in = i[0] ? 8'h7D : 8'h7E;
      tick(24);
      if (i == 253) check("errcount_254", err_count, 8'hFE);
      if (i == 254) check("errcount_255", err_count, 8'hFF);
    end
    check("errcount_sat", err_count, 8'hFF);
    check("err_pulses_300", n_err - e0, 300);
    check("sat_value_kept", value, 8'h93);
    check("sat_valid_kept", value_valid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
